// File: rtl/keypad_pkg.sv
// Shared types, key codes and key-index decoding for the 4x4 keypad scanner.
package keypad_pkg;

   localparam logic [3:0] KEY_NONE   = 4'b1111;
   localparam logic [3:0] KEY_CANCEL = 4'b1101;
   localparam logic [3:0] KEY_SET    = 4'b1110;
   localparam logic [3:0] KEY_ZERO   = 4'b1010;

   typedef enum logic [1:0] {FrNone, FrKey, FrMulti} frame_kind_e;

   // idx = {row, col}; kept zero unless kind is FrKey so frames compare by value.
   typedef struct packed {
      frame_kind_e kind;
      logic [3:0]  idx;
   } frame_t;

   localparam frame_t FRAME_NONE = '{kind: FrNone, idx: 4'd0};

   typedef enum logic [1:0] {StRow0, StRow1, StRow2, StRow3} scan_state_e;

   typedef struct packed {
      logic       emit;
      logic [3:0] code;
   } key_map_t;

   function automatic key_map_t key_map(input logic [3:0] idx);
      key_map_t   m;
      logic [3:0] row;
      logic [3:0] col;
      row    = {2'b00, idx[3:2]};
      col    = {2'b00, idx[1:0]};
      m.emit = 1'b1;
      m.code = KEY_NONE;
      if (col == 4'd3) begin
         m.emit = 1'b0;  // letter column A..D is never forwarded
      end else if (row != 4'd3) begin
         m.code = row * 4'd3 + col + 4'd1;
      end else begin
         case (col)
            4'd0:    m.code = KEY_CANCEL;
            4'd1:    m.code = KEY_ZERO;
            default: m.code = KEY_SET;
         endcase
      end
      return m;
   endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad matrix and keystroke bus between the scanner and its neighbours.
interface keypad_scanner_if;
   logic [3:0] col_in;
   logic [3:0] row_out;
   logic [3:0] key_code;
   logic       key_valid;

   modport master (
      input  col_in,
      output row_out,
      output key_code,
      output key_valid
   );

   modport slave (
      output col_in,
      input  row_out,
      input  key_code,
      input  key_valid
   );
endinterface

// File: rtl/keypad_debounce.sv
// Frame-level debouncer: a result must repeat DEBOUNCE_SCANS frames to become stable.
module keypad_debounce
   import keypad_pkg::*;
#(
   parameter int unsigned DEBOUNCE_SCANS = 4
) (
   input  logic   clk,
   input  logic   rst_n,
   input  logic   frame_done_i,
   input  frame_t frame_i,
   output frame_t stable_o
);

   frame_t     cand_q, cand_d;
   frame_t     stable_q, stable_d;
   logic [3:0] cnt_q, cnt_d;

   always_comb begin
      cand_d   = cand_q;
      cnt_d    = cnt_q;
      stable_d = stable_q;
      if (frame_done_i) begin
         if (frame_i == cand_q) begin
            cnt_d = (cnt_q == 4'hf) ? cnt_q : cnt_q + 4'd1;
         end else begin
            cand_d = frame_i;
            cnt_d  = 4'd1;
         end
         if (cnt_d >= 4'(DEBOUNCE_SCANS)) begin
            stable_d = cand_d;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cand_q   <= FRAME_NONE;
         cnt_q    <= 4'd0;
         stable_q <= FRAME_NONE;
      end else begin
         cand_q   <= cand_d;
         cnt_q    <= cnt_d;
         stable_q <= stable_d;
      end
   end

   assign stable_o = stable_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad front end: row scan, column sync, frame evaluation, debounce and
// single-cycle keystroke events on NONE -> KEY transitions of the stable state.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int unsigned SCAN_DIV       = 16,
   parameter int unsigned DEBOUNCE_SCANS = 4
) (
   input logic              clk,
   input logic              rst_n,
   keypad_scanner_if.master bus
);

   localparam int unsigned      SlotW    = $clog2(SCAN_DIV);
   localparam logic [SlotW-1:0] SlotLast = SlotW'(SCAN_DIV - 1);

   logic [3:0]       sync1_q, sync2_q;
   scan_state_e      state_q, state_d;
   logic [SlotW-1:0] slot_q, slot_d;
   logic [3:0]       row_out_q, row_out_d;
   logic [1:0]       acc_hits_q, acc_hits_d;
   logic [3:0]       acc_idx_q, acc_idx_d;
   logic [3:0]       col_act;
   logic [2:0]       row_hits, tot_hits;
   logic [1:0]       row_sel, col_sel;
   logic             slot_last, frame_done, fire;
   frame_t           frame, stable, stable_prev_q;
   key_map_t         km;
   logic [3:0]       key_code_q, key_code_d;
   logic             key_valid_q, key_valid_d;

   always_comb begin
      slot_last = (slot_q == SlotLast);
      state_d   = state_q;
      slot_d    = slot_q + SlotW'(1);
      row_out_d = row_out_q;
      if (slot_last) begin
         slot_d = '0;
         case (state_q)
            StRow0:  state_d = StRow1;
            StRow1:  state_d = StRow2;
            StRow2:  state_d = StRow3;
            default: state_d = StRow0;
         endcase
         row_out_d = ~(4'b0001 << state_d);
      end
   end

   // Hit count saturates at 2: anything beyond a single intersection is MULTI.
   always_comb begin
      col_act    = ~sync2_q;
      row_sel    = state_q;
      row_hits   = 3'(col_act[0]) + 3'(col_act[1]) + 3'(col_act[2]) + 3'(col_act[3]);
      col_sel    = 2'd0;
      for (int c = 3; c >= 0; c--) begin
         if (col_act[c]) col_sel = 2'(c);
      end
      tot_hits   = {1'b0, acc_hits_q} + row_hits;
      frame_done = slot_last && (state_q == StRow3);
      acc_hits_d = acc_hits_q;
      acc_idx_d  = acc_idx_q;
      if (slot_last) begin
         acc_hits_d = (tot_hits >= 3'd2) ? 2'd2 : tot_hits[1:0];
         if (row_hits == 3'd1) acc_idx_d = {row_sel, col_sel};
         if (frame_done) begin
            acc_hits_d = 2'd0;
            acc_idx_d  = 4'd0;
         end
      end
      frame = FRAME_NONE;
      if (tot_hits == 3'd1) begin
         frame.kind = FrKey;
         frame.idx  = (row_hits == 3'd1) ? {row_sel, col_sel} : acc_idx_q;
      end else if (tot_hits > 3'd1) begin
         frame.kind = FrMulti;
      end
   end

   keypad_debounce #(
      .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
   ) u_debounce (
      .clk         (clk),
      .rst_n       (rst_n),
      .frame_done_i(frame_done),
      .frame_i     (frame),
      .stable_o    (stable)
   );

   always_comb begin
      km          = key_map(stable.idx);
      fire        = (stable != stable_prev_q) && (stable_prev_q.kind == FrNone) &&
                    (stable.kind == FrKey) && km.emit;
      key_code_d  = fire ? km.code : KEY_NONE;
      key_valid_d = fire;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StRow0;
         slot_q    <= '0;
         row_out_q <= 4'b1110;
      end else begin
         state_q   <= state_d;
         slot_q    <= slot_d;
         row_out_q <= row_out_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q       <= 4'hf;
         sync2_q       <= 4'hf;
         acc_hits_q    <= 2'd0;
         acc_idx_q     <= 4'd0;
         stable_prev_q <= FRAME_NONE;
         key_code_q    <= KEY_NONE;
         key_valid_q   <= 1'b0;
      end else begin
         sync1_q       <= bus.col_in;
         sync2_q       <= sync1_q;
         acc_hits_q    <= acc_hits_d;
         acc_idx_q     <= acc_idx_d;
         stable_prev_q <= stable;
         key_code_q    <= key_code_d;
         key_valid_q   <= key_valid_d;
      end
   end

   assign bus.row_out   = row_out_q;
   assign bus.key_code  = key_code_q;
   assign bus.key_valid = key_valid_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: frame-aligned directed and random key masks checked
// against a run-length debounce model of the keypad.
module tb_keypad_scanner;

   localparam int unsigned SD = 4;
   localparam int unsigned DB = 4;
   localparam int unsigned FL = 4 * SD;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b1;
   logic [15:0] mask  = '0;
   logic [3:0]  col_drive;
   int          n_cmp  = 0;
   int          n_fail = 0;

   string       layout    = "123A456B789C*0#D";
   int          hist[$];
   int          stable_m  = -1;  // -1 none, -2 multi, else key index
   int          pend_code = -1;  // code expected in the next frame window

   keypad_scanner_if bus ();

   keypad_scanner #(
      .SCAN_DIV      (SD),
      .DEBOUNCE_SCANS(DB)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   // Physical keypad: a pressed key shorts its column to a driven-low row.
   always_comb begin
      col_drive = 4'hf;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (!bus.row_out[r] && mask[r*4+c]) col_drive[c] = 1'b0;
         end
      end
   end
   assign bus.col_in = col_drive;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] k(input int idx);
      return 16'(1) << idx;
   endfunction

   function automatic int code_of(input int idx);
      int ch;
      ch = int'(layout[idx]);
      if (ch >= "1" && ch <= "9") return ch - "0";
      if (ch == "0") return 10;
      if (ch == "*") return 13;
      if (ch == "#") return 14;
      return -1;
   endfunction

   function automatic int frame_of(input logic [15:0] m);
      if ($countones(m) == 0) return -1;
      if ($countones(m) > 1) return -2;
      for (int i = 0; i < 16; i++) begin
         if (m[i]) return i;
      end
      return -1;
   endfunction

   task automatic model_frame(input logic [15:0] m);
      int res;
      bit all_eq;
      res = frame_of(m);
      hist.push_back(res);
      if (hist.size() > DB) void'(hist.pop_front());
      pend_code = -1;
      if (hist.size() == DB) begin
         all_eq = 1'b1;
         foreach (hist[i]) if (hist[i] != res) all_eq = 1'b0;
         if (all_eq && res != stable_m) begin
            if (stable_m == -1 && res >= 0 && code_of(res) >= 0) pend_code = code_of(res);
            stable_m = res;
         end
      end
   endtask

   // Called at the negedge of cycle 0 of a frame; returns at cycle 0 of the next.
   task automatic run_frame(input logic [15:0] m);
      int         pulses;
      int         exp_now;
      logic [3:0] code;
      logic [3:0] exp_row;
      pulses  = 0;
      code    = 4'hf;
      exp_now = pend_code;
      mask    = m;
      model_frame(m);
      for (int i = 0; i < FL; i++) begin
         exp_row = ~(4'b0001 << (i / SD));
         check("row_out", {12'd0, bus.row_out}, {12'd0, exp_row});
         check("valid_vs_code", {15'd0, bus.key_valid}, {15'd0, bus.key_code != 4'hf});
         if (bus.key_valid) begin
            pulses++;
            code = bus.key_code;
         end
         @(negedge clk);
      end
      check("pulse_count", 16'(pulses), (exp_now >= 0) ? 16'd1 : 16'd0);
      if (exp_now >= 0) check("key_code", {12'd0, code}, {12'd0, exp_now[3:0]});
   endtask

   task automatic align();
      int n;
      n = 0;
      while (bus.row_out !== 4'b0111 && n < 8 * FL) begin
         @(negedge clk);
         n++;
      end
      while (bus.row_out !== 4'b1110 && n < 8 * FL) begin
         @(negedge clk);
         n++;
      end
      check("align_timeout", {15'd0, n < 8 * FL}, 16'd1);
   endtask

   task automatic reset_and_align();
      rst_n = 1'b0;
      #1;
      check("rst_row_out", {12'd0, bus.row_out}, 16'h000e);
      check("rst_key_code", {12'd0, bus.key_code}, 16'h000f);
      check("rst_key_valid", {15'd0, bus.key_valid}, 16'd0);
      repeat (3) @(negedge clk);
      check("rst_hold_row_out", {12'd0, bus.row_out}, 16'h000e);
      rst_n = 1'b1;
      hist.delete();
      stable_m  = -1;
      pend_code = -1;
      align();
      model_frame(mask);  // the first post-reset frame completes during alignment
   endtask

   initial begin
      int          sel;
      int          len;
      logic [15:0] m;

      #1;
      reset_and_align();
      repeat (3) run_frame(16'd0);

      // Clean "5"
      repeat (10) run_frame(k(5));
      repeat (6) run_frame(16'd0);

      // Bouncing "#"
      run_frame(k(14));
      run_frame(16'd0);
      run_frame(k(14));
      repeat (6) run_frame(k(14));
      repeat (6) run_frame(16'd0);

      // Hold "0", roll to "8", release, press "8"
      repeat (50) run_frame(k(13));
      repeat (6) run_frame(k(9));
      repeat (6) run_frame(16'd0);
      repeat (6) run_frame(k(9));
      repeat (6) run_frame(16'd0);

      // "1"+"3", then A, release, then "*"
      repeat (6) run_frame(k(0) | k(2));
      repeat (6) run_frame(k(3));
      repeat (6) run_frame(16'd0);
      repeat (6) run_frame(k(12));
      repeat (6) run_frame(16'd0);

      // Reset mid-frame with "5" held, key still held afterwards
      repeat (2) run_frame(k(5));
      repeat (7) @(negedge clk);
      reset_and_align();
      repeat (6) run_frame(k(5));
      repeat (4) run_frame(16'd0);

      for (int s = 0; s < 40; s++) begin
         sel = $urandom_range(0, 3);
         len = $urandom_range(1, 7);
         case (sel)
            0:       m = 16'd0;
            1, 2:    m = k($urandom_range(0, 15));
            default: m = k($urandom_range(0, 15)) | k($urandom_range(0, 15));
         endcase
         repeat (len) run_frame(m);
      end
      repeat (DB + 2) run_frame(16'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Matrix-keypad front end for the electronic lock: scans a 4x4 active-low keypad, synchronises and debounces the column returns, and emits each clean key press as a single-cycle 4-bit code. It sits directly upstream of the lock FSM. `key_code` drives the lock's 4-bit user-input bus, which treats 4'b1111 as "no input" and any other value as one keystroke per cycle.

## Interface
- `SCAN_DIV`, default 16: clock cycles each row is driven; legal range >= 2.
- `DEBOUNCE_SCANS`, default 4: consecutive identical frames required to accept a new state; legal range 1..15.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `col_in` input 4: keypad columns, active-low with external pull-ups, asynchronous to `clk`.
- `row_out` output 4: row drive, one-hot active-low.
- `key_code` output 4: keystroke code for one cycle, else 4'b1111.
- `key_valid` output 1: high exactly in the cycle `key_code` != 4'b1111.

## Operation
- **Keypad layout** (row r, column c):
  - row0: 1 2 3 A
  - row1: 4 5 6 B
  - row2: 7 8 9 C
  - row3: * 0 # D
- **Codes:**
  - digits 1..9 -> 4'b0001..4'b1001
  - 0 -> 4'b1010
  - `*` -> 4'b1101 (cancel)
  - `#` -> 4'b1110 (set passcode)
  - A..D: recognised as keys but never emitted
- **Synchroniser:** `col_in` passes through a 2-flop synchroniser; all logic uses the synchronised value.
- **Scan FSM, states ROW0..ROW3:**
  - Each state drives its row low for `SCAN_DIV` cycles, then advances ROW0->ROW1->ROW2->ROW3->ROW0.
  - Columns are sampled in the last cycle of each row slot.
- **Frame result:** evaluated after the ROW3 sample.
  - NONE if no active column in any row.
  - KEY(index) if exactly one row/column intersection is active.
  - MULTI otherwise.
- **Debounce:**
  - Keep a candidate result and a saturating 4-bit match count.
  - A frame equal to the candidate increments the count; a different frame loads the new candidate with count=1.
  - When count reaches `DEBOUNCE_SCANS`, the candidate becomes the stable state.
- **Event rule:**
  - An event fires only on a stable transition NONE -> KEY(k) where k is an emittable key.
  - The event drives `key_code`=code(k) and `key_valid`=1 for one cycle.
- **Release required before the next event:**
  - KEY(a) -> KEY(b), KEY -> MULTI, or MULTI -> KEY produce no event.
  - A held key never repeats.
  - A stable A..D or MULTI also blocks later events until stable NONE.

## Timing
- **Reset values (async assert):**
  - `row_out`=4'b1110 (ROW0), `key_code`=4'b1111, `key_valid`=0.
  - Synchroniser flops 4'b1111.
  - Slot counter 0, candidate and stable = NONE, match count 0.
- **Deassertion:** the scan starts with ROW0 slot cycle 0 on the first clock edge after deassertion.
- **Frame length:** 4·`SCAN_DIV` cycles.
- **Event latency:** the event registers one cycle after the frame evaluation that makes the state stable. Worst case from contact closure: 2 sync cycles + (`DEBOUNCE_SCANS`+1) frames + 1 cycle.
- **Key held through reset:** stable state starts as NONE, so a key held through reset yields one event after debounce.
- **Reset mid-event:** `key_valid` clears immediately.
- **Bounce:** bounce shorter than `DEBOUNCE_SCANS` frames never changes the stable state.
- **Event cadence:** `key_valid` is never high on two consecutive cycles; the minimum spacing between events is 2·`DEBOUNCE_SCANS` frames.

## Structure
- **Package `keypad_pkg`:**
  - `KEY_NONE`=4'b1111, `KEY_CANCEL`=4'b1101, `KEY_SET`=4'b1110, `KEY_ZERO`=4'b1010.
  - Frame-result enum (NONE, KEY, MULTI) plus a 4-bit key index.
  - Function mapping key index -> code/emittable flag.
  - Scan-state enum ROW0..ROW3.
- **Sub-module `keypad_debounce`:** candidate, match counter and stable-state register, with a `frame_done` strobe input. The scanner top holds the synchroniser, scan FSM, frame accumulator and event register.

## Test plan
- **Clean digit press:** press "5" (row1, col1) for 10 frames, then release, `DEBOUNCE_SCANS`=4 -> exactly one cycle with `key_code`=4'b0101 and `key_valid`=1, roughly 5 frames after press; `key_code`=4'b1111 otherwise.
- **Bounce rejection:** toggle `col_in` for "#" every frame for 3 frames, then hold 6 frames -> a single 4'b1110 pulse, no extra pulses.
- **Hold and roll-over:** hold "0" for 50 frames -> one 4'b1010 pulse. Slide to "8" without release -> no event. Release and press "8" -> one 4'b1000 pulse.
- **Multi-key and letters:** press "1" and "3" together, then press A alone -> no events. After release, "*" -> 4'b1101 pulse.
- **Reset:** assert `rst_n` low mid-frame while a key is held -> `row_out`=4'b1110, `key_code`=4'b1111, `key_valid`=0 immediately. After release of reset with the key still held -> one pulse after debounce.
